// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
//   Shared widths, FSM state encoding and a small helper for the memory
//   arbiter that sits between the fetch stage, the data stage and a
//   single-ported unified memory.
//   Contents:
//     WORD / ADDR      data and address widths
//     STARVE_W         width of the fetch starvation counter (holds 0..15)
//     arb_state_e      arbiter FSM states (IDLE / FETCH / DATA)
//     sat_inc()        saturating increment for the starvation counter
package mem_arbiter_pkg;

    localparam int unsigned WORD     = 32;
    localparam int unsigned ADDR     = 32;
    localparam int unsigned STARVE_W = 4;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_FETCH = 2'd1,
        ARB_DATA  = 2'd2
    } arb_state_e;

    // Holds at all-ones instead of wrapping back to zero.
    function automatic logic [STARVE_W-1:0] sat_inc(input logic [STARVE_W-1:0] v);
        logic [STARVE_W-1:0] one;
        one = {{(STARVE_W-1){1'b0}}, 1'b1};
        return (v == {STARVE_W{1'b1}}) ? v : v + one;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
//   Bus between the arbiter and the single-ported, variable-latency memory.
//   Protocol: the master raises req together with a stable addr/we/wdata and
//   keeps all of them unchanged until the slave answers with a one-cycle ack
//   pulse. The ack cycle is the last cycle of req; for reads, rdata is valid
//   in the ack cycle. A request may be dropped without an ack only by reset.
//   Signals:
//     req    master -> slave  request held until ack
//     we     master -> slave  1 = write, 0 = read
//     addr   master -> slave  ADDR-bit address
//     wdata  master -> slave  WORD-bit write data
//     rdata  slave  -> master WORD-bit read data, valid with ack
//     ack    slave  -> master one-cycle completion pulse
interface mem_arbiter_if;
    import mem_arbiter_pkg::*;

    logic            req;
    logic            we;
    logic [ADDR-1:0] addr;
    logic [WORD-1:0] wdata;
    logic [WORD-1:0] rdata;
    logic            ack;

    modport master (
        output req,
        output we,
        output addr,
        output wdata,
        input  rdata,
        input  ack
    );

    modport slave (
        input  req,
        input  we,
        input  addr,
        input  wdata,
        output rdata,
        output ack
    );

endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one single-ported unified memory between instruction fetch and
//   the load/store stage. Each stage holds its request until it sees its
//   stall low for one cycle; the arbiter turns that into a held memory
//   request completed by an ack pulse. Data wins ties unless fetch has
//   already lost STARVE_MAX consecutive contested grants.
//   Ports:
//     clk, rst        clock, asynchronous active-low reset
//     if_req_i        fetch request, held until if_stall_o seen low
//     if_addr_i       fetch address, stable while if_req_i
//     if_inst_o       registered instruction
//     if_stall_o      stall to fetch stage
//     flush_i         branch taken: discard in-flight fetch result
//     dm_req_i        data request, held until dm_stall_o seen low
//     dm_we_i         data write enable
//     dm_addr_i       data address
//     dm_wdata_i      store data
//     dm_rdata_o      registered load data
//     dm_stall_o      stall to data stage
//     mem             memory bus (master side)
//     state_o         current FSM state, for observation
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             if_req_i,
    input  logic [ADDR-1:0]  if_addr_i,
    output logic [WORD-1:0]  if_inst_o,
    output logic             if_stall_o,
    input  logic             flush_i,

    input  logic             dm_req_i,
    input  logic             dm_we_i,
    input  logic [ADDR-1:0]  dm_addr_i,
    input  logic [WORD-1:0]  dm_wdata_i,
    output logic [WORD-1:0]  dm_rdata_o,
    output logic             dm_stall_o,

    mem_arbiter_if.master    mem,

    output arb_state_e       state_o
);

    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

    arb_state_e          state_q;
    logic                mem_req_q;
    logic                mem_we_q;
    logic [ADDR-1:0]     mem_addr_q;
    logic [WORD-1:0]     mem_wdata_q;
    logic [WORD-1:0]     if_inst_q;
    logic [WORD-1:0]     dm_rdata_q;
    logic                if_done_q;
    logic                dm_done_q;
    logic                kill_q;
    logic [STARVE_W-1:0] starve_q;

    logic                if_elig;
    logic                dm_elig;
    logic                data_wins;
    logic [STARVE_W-1:0] starve_d;

    // A requester in its done cycle is still holding req (it only drops it
    // after seeing the stall low), so it must be masked or it would be
    // granted a second time for the same transaction.
    assign if_elig   = if_req_i & ~if_done_q;
    assign dm_elig   = dm_req_i & ~dm_done_q;
    assign data_wins = dm_elig & ((starve_q < STARVE_LIM) | ~if_elig);
    assign starve_d  = sat_inc(starve_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ARB_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_inst_q   <= '0;
            dm_rdata_q  <= '0;
            if_done_q   <= 1'b0;
            dm_done_q   <= 1'b0;
            kill_q      <= 1'b0;
            starve_q    <= '0;
        end else begin
            // Done flags are single-cycle pulses.
            if_done_q <= 1'b0;
            dm_done_q <= 1'b0;

            unique case (state_q)
                ARB_IDLE: begin
                    // Acks arriving here are stray and are ignored.
                    kill_q <= 1'b0;
                    if (data_wins) begin
                        state_q     <= ARB_DATA;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= dm_we_i;
                        mem_addr_q  <= dm_addr_i;
                        mem_wdata_q <= dm_wdata_i;
                        // Only a contested grant counts against fetch.
                        if (if_elig) begin
                            starve_q <= starve_d;
                        end
                    end else if (if_elig) begin
                        state_q    <= ARB_FETCH;
                        mem_req_q  <= 1'b1;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= if_addr_i;
                        starve_q   <= '0;
                    end
                end

                ARB_FETCH: begin
                    if (mem.ack) begin
                        state_q   <= ARB_IDLE;
                        mem_req_q <= 1'b0;
                        kill_q    <= 1'b0;
                        // A flush in the ack cycle itself also discards the
                        // word; fetch stays stalled and re-requests with
                        // its new address from IDLE.
                        if (!(kill_q || flush_i)) begin
                            if_inst_q <= mem.rdata;
                            if_done_q <= 1'b1;
                        end
                    end else if (flush_i) begin
                        kill_q <= 1'b1;
                    end
                end

                ARB_DATA: begin
                    if (mem.ack) begin
                        state_q   <= ARB_IDLE;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        dm_done_q <= 1'b1;
                        if (!mem_we_q) begin
                            dm_rdata_q <= mem.rdata;
                        end
                    end
                end

                default: begin
                    state_q   <= ARB_IDLE;
                    mem_req_q <= 1'b0;
                    mem_we_q  <= 1'b0;
                end
            endcase
        end
    end

    assign mem.req     = mem_req_q;
    assign mem.we      = mem_we_q;
    assign mem.addr    = mem_addr_q;
    assign mem.wdata   = mem_wdata_q;

    assign if_inst_o   = if_inst_q;
    assign dm_rdata_o  = dm_rdata_q;
    assign if_stall_o  = if_req_i & ~if_done_q;
    assign dm_stall_o  = dm_req_i & ~dm_done_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Directed bench for mem_arbiter. Stimulus tasks push the expected memory
//   grants and the expected fetch/load results into queues; a memory
//   responder pops and checks each grant as it appears, and a monitor pops
//   and checks each result in the requester's done cycle.
//   Outputs are sampled on the falling edge; inputs change 1 time unit later.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int TIMEOUT = 400;

    logic            clk;
    logic            rst;
    logic            if_req;
    logic [31:0]     if_addr;
    logic [31:0]     if_inst_o;
    logic            if_stall_o;
    logic            flush;
    logic            dm_req;
    logic            dm_we;
    logic [31:0]     dm_addr;
    logic [31:0]     dm_wdata;
    logic [31:0]     dm_rdata_o;
    logic            dm_stall_o;
    arb_state_e      state_o;

    mem_arbiter_if mem_bus ();

    mem_arbiter #(.STARVE_MAX(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .if_req_i   (if_req),
        .if_addr_i  (if_addr),
        .if_inst_o  (if_inst_o),
        .if_stall_o (if_stall_o),
        .flush_i    (flush),
        .dm_req_i   (dm_req),
        .dm_we_i    (dm_we),
        .dm_addr_i  (dm_addr),
        .dm_wdata_i (dm_wdata),
        .dm_rdata_o (dm_rdata_o),
        .dm_stall_o (dm_stall_o),
        .mem        (mem_bus.master),
        .state_o    (state_o)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [64:0] exp_grant_q[$];   // {we, addr, wdata}
    logic [31:0] exp_if_q[$];
    logic [31:0] exp_dm_q[$];
    logic [31:0] mem_model [logic [31:0]];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s timed out t=%0t", name, $time);
    endtask

    task automatic push_grant(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        exp_grant_q.push_back({we, addr, wdata});
    endtask

    // ---------------- memory responder ----------------
    int          resp_lat  = 0;
    int          grant_cnt = 0;
    int          lat_cnt   = 0;
    bit          busy      = 1'b0;
    logic        r_ack     = 1'b0;
    logic [31:0] r_data    = 32'h0;
    logic        spur_ack  = 1'b0;

    initial begin
        mem_bus.ack   = 1'b0;
        mem_bus.rdata = 32'h0;
    end

    always begin
        logic [64:0] g;
        @(negedge clk);
        if (!mem_bus.req) begin
            busy  = 1'b0;
            r_ack = 1'b0;
        end else begin
            if (!busy) begin
                busy    = 1'b1;
                lat_cnt = 0;
                grant_cnt++;
                if (exp_grant_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL grant_unexpected addr=%0h we=%0b t=%0t", mem_bus.addr, mem_bus.we, $time);
                end else begin
                    g = exp_grant_q.pop_front();
                    check("grant_we", 64'(mem_bus.we), 64'(g[64]));
                    check("grant_addr", 64'(mem_bus.addr), 64'(g[63:32]));
                    if (g[64]) check("grant_wdata", 64'(mem_bus.wdata), 64'(g[31:0]));
                end
            end else begin
                lat_cnt++;
            end
            r_ack = 1'b0;
            if (lat_cnt == resp_lat) begin
                r_ack = 1'b1;
                if (mem_bus.we) mem_model[mem_bus.addr] = mem_bus.wdata;
                else r_data = mem_model.exists(mem_bus.addr) ? mem_model[mem_bus.addr] : 32'h0;
            end
        end
        #2;
        mem_bus.ack   = r_ack | spur_ack;
        mem_bus.rdata = r_data;
    end

    // ---------------- result monitor ----------------
    always begin
        @(negedge clk);
        if (rst && if_req && !if_stall_o) begin
            if (exp_if_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL if_done_unexpected inst=%0h t=%0t", if_inst_o, $time);
            end else begin
                check("if_inst", 64'(if_inst_o), 64'(exp_if_q.pop_front()));
            end
        end
        if (rst && dm_req && !dm_stall_o) begin
            if (exp_dm_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dm_done_unexpected rdata=%0h t=%0t", dm_rdata_o, $time);
            end else begin
                check("dm_rdata", 64'(dm_rdata_o), 64'(exp_dm_q.pop_front()));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic apply_reset();
        @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic do_fetch(input logic [31:0] addr, input int lat, input logic [31:0] exp_inst,
                            input int exp_cycles, input bit spur);
        int cycles;
        bit done;
        push_grant(1'b0, addr, 32'h0);
        exp_if_q.push_back(exp_inst);
        resp_lat = lat;
        @(negedge clk);
        #1;
        if_req   = 1'b1;
        if_addr  = addr;
        spur_ack = spur;
        cycles   = 0;
        done     = 1'b0;
        while (!done && cycles < TIMEOUT) begin
            @(negedge clk);
            cycles++;
            spur_ack = 1'b0;
            if (!if_stall_o) done = 1'b1;
        end
        if (!done) timeout_fail("fetch_wait");
        else check("fetch_cycles", 64'(cycles), 64'(exp_cycles));
        #1 if_req = 1'b0;
    endtask

    task automatic do_data(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input int lat, input logic [31:0] exp_rdata, input int exp_cycles);
        int cycles;
        bit done;
        push_grant(we, addr, we ? wdata : 32'h0);
        exp_dm_q.push_back(exp_rdata);
        resp_lat = lat;
        @(negedge clk);
        #1;
        dm_req   = 1'b1;
        dm_we    = we;
        dm_addr  = addr;
        dm_wdata = wdata;
        cycles   = 0;
        done     = 1'b0;
        while (!done && cycles < TIMEOUT) begin
            @(negedge clk);
            cycles++;
            if (!dm_stall_o) done = 1'b1;
        end
        if (!done) timeout_fail("data_wait");
        else check("data_cycles", 64'(cycles), 64'(exp_cycles));
        #1 dm_req = 1'b0;
    endtask

    // Both stages request fetch 0x100 / load 0x200 until n fetches complete.
    // With gate set, fetch briefly drops its request during each data done
    // cycle, so every IDLE decision with fetch requesting is a contested one.
    task automatic run_both(input int n, input bit gate);
        int  cycles;
        int  fetches;
        bit  g;
        resp_lat = 1;
        @(negedge clk);
        #1;
        if_req   = 1'b1;
        if_addr  = 32'h100;
        dm_req   = 1'b1;
        dm_we    = 1'b0;
        dm_addr  = 32'h200;
        dm_wdata = 32'h0;
        cycles   = 0;
        fetches  = 0;
        while (cycles < TIMEOUT) begin
            @(negedge clk);
            cycles++;
            if (if_req && !if_stall_o) fetches++;
            if (fetches == n) break;
            g = dm_req && !dm_stall_o;
            #1 if (gate) if_req = !g;
        end
        if (fetches != n) timeout_fail("both_wait");
        #1;
        if_req = 1'b0;
        dm_req = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int g0;
        rst      = 1'b0;
        if_req   = 1'b1;
        if_addr  = 32'h0;
        flush    = 1'b0;
        dm_req   = 1'b1;
        dm_we    = 1'b0;
        dm_addr  = 32'h0;
        dm_wdata = 32'h0;
        mem_model[32'h10]  = 32'hDEADBEEF;
        mem_model[32'h20]  = 32'hBAD00020;
        mem_model[32'h30]  = 32'hC0DE0030;
        mem_model[32'h100] = 32'h11110100;
        mem_model[32'h200] = 32'hA5A50200;

        // Reset values; stalls follow their requests while in reset.
        @(negedge clk);
        @(negedge clk);
        check("rst_state", 64'(state_o), 64'(ARB_IDLE));
        check("rst_mem_req", 64'(mem_bus.req), 64'd0);
        check("rst_mem_we", 64'(mem_bus.we), 64'd0);
        check("rst_mem_addr", 64'(mem_bus.addr), 64'd0);
        check("rst_mem_wdata", 64'(mem_bus.wdata), 64'd0);
        check("rst_if_inst", 64'(if_inst_o), 64'd0);
        check("rst_dm_rdata", 64'(dm_rdata_o), 64'd0);
        check("rst_if_stall", 64'(if_stall_o), 64'd1);
        check("rst_dm_stall", 64'(dm_stall_o), 64'd1);
        #1;
        if_req = 1'b0;
        dm_req = 1'b0;
        @(negedge clk);
        #1 rst = 1'b1;

        // Stray ack while idle with nothing requested.
        @(negedge clk);
        #1 spur_ack = 1'b1;
        @(negedge clk);
        spur_ack = 1'b0;
        @(negedge clk);
        check("spur_state", 64'(state_o), 64'(ARB_IDLE));
        check("spur_mem_req", 64'(mem_bus.req), 64'd0);

        // Fetch, zero-latency ack: stall low two cycles after the request.
        g0 = grant_cnt;
        do_fetch(32'h10, 0, 32'hDEADBEEF, 2, 1'b0);
        check("fetch_one_req", 64'(grant_cnt - g0), 64'd1);

        // Store then load, latency 3: five cycles each; store keeps rdata.
        do_data(1'b1, 32'h40, 32'h12345678, 3, 32'h0, 5);
        do_data(1'b0, 32'h40, 32'h0, 3, 32'h12345678, 5);

        // Flush during a latency-5 fetch: result dropped, refetch at 0x30.
        push_grant(1'b0, 32'h20, 32'h0);
        push_grant(1'b0, 32'h30, 32'h0);
        exp_if_q.push_back(32'hC0DE0030);
        resp_lat = 5;
        begin
            int  n;
            bit  done;
            @(negedge clk);
            #1;
            if_req  = 1'b1;
            if_addr = 32'h20;
            n = 0;
            while (!mem_bus.req && n < TIMEOUT) begin @(negedge clk); n++; end
            @(negedge clk);
            #1 flush = 1'b1;
            @(negedge clk);
            #1 flush = 1'b0;
            n = 0;
            while (mem_bus.req && n < TIMEOUT) begin @(negedge clk); n++; end
            if (n >= TIMEOUT) timeout_fail("flush_ack_wait");
            check("flush_if_stall", 64'(if_stall_o), 64'd1);
            check("flush_if_inst", 64'(if_inst_o), 64'hDEADBEEF);
            #1;
            if_addr  = 32'h30;
            resp_lat = 1;
            n = 0;
            done = 1'b0;
            while (!done && n < TIMEOUT) begin
                @(negedge clk);
                n++;
                if (!if_stall_o) done = 1'b1;
            end
            if (!done) timeout_fail("refetch_wait");
            #1 if_req = 1'b0;
        end

        // Stray ack in the same IDLE cycle as a fetch request: the real
        // ack (latency 2) still governs completion.
        do_fetch(32'h10, 2, 32'hDEADBEEF, 4, 1'b1);

        // Reset in the middle of a long load: bus drops immediately.
        push_grant(1'b0, 32'h44, 32'h0);
        resp_lat = 10;
        begin
            int n;
            @(negedge clk);
            #1;
            dm_req  = 1'b1;
            dm_we   = 1'b0;
            dm_addr = 32'h44;
            n = 0;
            while (!mem_bus.req && n < TIMEOUT) begin @(negedge clk); n++; end
            @(negedge clk);
            @(negedge clk);
            #1 rst = 1'b0;
            #1;
            check("abort_mem_req", 64'(mem_bus.req), 64'd0);
            check("abort_state", 64'(state_o), 64'(ARB_IDLE));
            check("abort_mem_addr", 64'(mem_bus.addr), 64'd0);
            check("abort_dm_rdata", 64'(dm_rdata_o), 64'd0);
            check("abort_if_inst", 64'(if_inst_o), 64'd0);
            check("abort_dm_stall", 64'(dm_stall_o), 64'd1);
            dm_req = 1'b0;
            @(negedge clk);
            #1 rst = 1'b1;
        end
        do_data(1'b0, 32'h40, 32'h0, 1, 32'h12345678, 3);

        // Contested arbitration from a clean counter: D,D,D,D,F then one
        // uncontested D in fetch's done cycle followed by four contested D,F.
        apply_reset();
        for (int i = 0; i < 4; i++) push_grant(1'b0, 32'h200, 32'h0);
        push_grant(1'b0, 32'h100, 32'h0);
        for (int i = 0; i < 5; i++) push_grant(1'b0, 32'h200, 32'h0);
        push_grant(1'b0, 32'h100, 32'h0);
        for (int i = 0; i < 9; i++) exp_dm_q.push_back(32'hA5A50200);
        for (int i = 0; i < 2; i++) exp_if_q.push_back(32'h11110100);
        run_both(2, 1'b1);

        // Both holding requests: each done cycle hands the slot to the
        // other requester, so grants alternate D,F.
        for (int i = 0; i < 3; i++) begin
            push_grant(1'b0, 32'h200, 32'h0);
            push_grant(1'b0, 32'h100, 32'h0);
            exp_dm_q.push_back(32'hA5A50200);
            exp_if_q.push_back(32'h11110100);
        end
        run_both(3, 1'b0);

        repeat (4) @(negedge clk);
        check("grant_q_empty", 64'(exp_grant_q.size()), 64'd0);
        check("if_q_empty", 64'(exp_if_q.size()), 64'd0);
        check("dm_q_empty", 64'(exp_dm_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
